// File: rtl/dpram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dpram_pkg                                                                  |
// | Shared types, write-mode encodings and byte-merge helper for dual_port_ram |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dpram_pkg;

  typedef enum logic [1:0] {
    WRM_NO_CHANGE   = 2'd0,
    WRM_WRITE_FIRST = 2'd1,
    WRM_READ_FIRST  = 2'd2
  } wr_mode_e;

  // Widest word merge_be handles; callers zero-extend and truncate around it.
  localparam int DPRAM_MAX_W  = 1024;
  localparam int DPRAM_MAX_BE = DPRAM_MAX_W / 8;

  typedef logic [DPRAM_MAX_W-1:0]  dpram_word_t;
  typedef logic [DPRAM_MAX_BE-1:0] dpram_be_t;

  function automatic dpram_word_t merge_be(input dpram_word_t old_w,
                                           input dpram_word_t new_w,
                                           input dpram_be_t   be);
    dpram_word_t res;
    res = old_w;
    for (int i = 0; i < DPRAM_MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dpram_rd_pipe                                                              |
// | Per-port read output stage; DPRAM_OUT_REG_EN adds a second register stage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dpram_rd_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] rdat_in,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid
);

  logic [WIDTH-1:0] dout_d, dout_q;
  logic             dvalid_d, dvalid_q;

  always_comb begin
    dvalid_d = vld_in;
    dout_d   = vld_in ? rdat_in : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [WIDTH-1:0] dout2_d, dout2_q;
  logic             dvalid2_d, dvalid2_q;

  always_comb begin
    dvalid2_d = dvalid_q;
    dout2_d   = dvalid_q ? dout_q : dout2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout2_q   <= '0;
      dvalid2_q <= 1'b0;
    end else begin
      dout2_q   <= dout2_d;
      dvalid2_q <= dvalid2_d;
    end
  end

  assign dout   = dout2_q;
  assign dvalid = dvalid2_q;
`else
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
`endif

endmodule
`default_nettype wire

// File: rtl/dual_port_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dual_port_ram                                                              |
// | True dual-port RAM with byte enables, write modes and collision flag.      |
// | Optional macro DPRAM_OUT_REG_EN adds one output register stage.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dual_port_ram
  import dpram_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BE_W    = WIDTH / 8,
  parameter int WR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_a,
  input  logic             we_a,
  input  logic [BE_W-1:0]  be_a,
  input  logic [ADDR-1:0]  addr_a,
  input  logic [WIDTH-1:0] din_a,
  output logic [WIDTH-1:0] dout_a,
  output logic             dvalid_a,
  input  logic             en_b,
  input  logic             we_b,
  input  logic [BE_W-1:0]  be_b,
  input  logic [ADDR-1:0]  addr_b,
  input  logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout_b,
  output logic             dvalid_b,
  output logic             coll
);

  localparam wr_mode_e MODE = wr_mode_e'(WR_MODE);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ok_a, ok_b, wr_a, wr_b, hit_ab, same_wr;
  logic [ADDR-1:0]  idx_a, idx_b;
  logic [WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, new_a, new_b;
  logic             vld_a, vld_b;
  logic [WIDTH-1:0] rdat_a, rdat_b;
  logic             coll_d, coll_q;

  always_comb begin
    ok_a    = 32'(addr_a) < 32'(DEPTH);
    ok_b    = 32'(addr_b) < 32'(DEPTH);
    idx_a   = ok_a ? addr_a : '0;
    idx_b   = ok_b ? addr_b : '0;
    old_a   = ok_a ? mem_q[idx_a] : '0;
    old_b   = ok_b ? mem_q[idx_b] : '0;
    wr_a    = en_a & we_a & ~rst & ok_a & (|be_a);
    wr_b    = en_b & we_b & ~rst & ok_b & (|be_b);
    hit_ab  = (addr_a == addr_b);
    same_wr = wr_a & wr_b & hit_ab;

    // On a shared-address write B's bytes land first and A overlays them.
    mrg_b = WIDTH'(merge_be(dpram_word_t'(old_b), dpram_word_t'(din_b), dpram_be_t'(be_b)));
    mrg_a = WIDTH'(merge_be(dpram_word_t'(same_wr ? mrg_b : old_a),
                            dpram_word_t'(din_a), dpram_be_t'(be_a)));

    new_a = !ok_a ? '0 : wr_a ? mrg_a : (wr_b & hit_ab) ? mrg_b : old_a;
    new_b = !ok_b ? '0 : (wr_a & hit_ab) ? mrg_a : wr_b ? mrg_b : old_b;

    coll_d = same_wr & (|(be_a & be_b));

    vld_a  = 1'b0;
    rdat_a = old_a;
    if (en_a & ~rst) begin
      if (!we_a) begin
        vld_a = 1'b1;
      end else if (MODE == WRM_WRITE_FIRST) begin
        vld_a  = 1'b1;
        rdat_a = new_a;
      end else if (MODE == WRM_READ_FIRST) begin
        vld_a = 1'b1;
      end
    end

    vld_b  = 1'b0;
    rdat_b = old_b;
    if (en_b & ~rst) begin
      if (!we_b) begin
        vld_b = 1'b1;
      end else if (MODE == WRM_WRITE_FIRST) begin
        vld_b  = 1'b1;
        rdat_b = new_b;
      end else if (MODE == WRM_READ_FIRST) begin
        vld_b = 1'b1;
      end
    end
  end

  // Port A's merged word already contains B's surviving bytes on a shared address.
  always_ff @(posedge clk) begin
    if (wr_a)             mem_q[idx_a] <= mrg_a;
    if (wr_b && !same_wr) mem_q[idx_b] <= mrg_b;
  end

  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_d;
  end

`ifdef DPRAM_OUT_REG_EN
  logic coll2_q;

  always_ff @(posedge clk) begin
    if (rst) coll2_q <= 1'b0;
    else     coll2_q <= coll_q;
  end

  assign coll = coll2_q;
`else
  assign coll = coll_q;
`endif

  dpram_rd_pipe #(.WIDTH(WIDTH)) u_pipe_a (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_a),
    .rdat_in (rdat_a),
    .dout    (dout_a),
    .dvalid  (dvalid_a)
  );

  dpram_rd_pipe #(.WIDTH(WIDTH)) u_pipe_b (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_b),
    .rdat_in (rdat_b),
    .dout    (dout_b),
    .dvalid  (dvalid_b)
  );

endmodule
`default_nettype wire
